// File: rtl/flow_table_updater.sv
// flow_table_updater
//
// Purpose: create/update engine for a hashed flow table held in an external
// single-port RAM. Each accepted packet descriptor is looked up by linear
// probing from its home slot. A free slot creates a new record, a matching
// key updates the record with saturating counters, and running out of probes
// drops the packet. Some writes also request an export of the written slot
// over a ready/valid handshake.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   in_valid/in_ready      packet descriptor handshake (in_ready only in IDLE)
//   in_key, in_hash        5-tuple (key[7:0] = IP protocol) and home slot
//   in_len, in_ts          IP total length, timestamp
//   in_flags               TCP flags
//   mem_en/we/addr/din     flow table RAM request
//   mem_dout               RAM read data, valid the cycle after a read
//   export_valid/ready     export request handshake
//   export_addr            slot to export
//   collision_counter      packets dropped for lack of a free/matching slot
//   probe_counter          extra probes performed
//
// Record layout (MSB..LSB):
//   {valid, key, tcp_flags[7:0], first_ts[31:0], last_ts[31:0], pkt_cnt, byte_cnt}

module flow_table_updater #(
  parameter int ADDR_W      = 12,
  parameter int KEY_W       = 104,
  parameter int CNT_W       = 32,
  parameter int PROBE_DEPTH = 4,
  parameter int ENTRY_W     = 1 + KEY_W + 8 + 64 + 2 * CNT_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [ADDR_W-1:0]  in_hash,
  input  logic [15:0]        in_len,
  input  logic [31:0]        in_ts,
  input  logic [7:0]         in_flags,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [ENTRY_W-1:0] mem_din,
  input  logic [ENTRY_W-1:0] mem_dout,
  output logic               export_valid,
  input  logic               export_ready,
  output logic [ADDR_W-1:0]  export_addr,
  output logic [31:0]        collision_counter,
  output logic [31:0]        probe_counter
);

  localparam int PW      = (PROBE_DEPTH > 1) ? $clog2(PROBE_DEPTH) : 1;
  localparam int PKT_LSB = CNT_W;
  localparam int LTS_LSB = 2 * CNT_W;
  localparam int FTS_LSB = 2 * CNT_W + 32;
  localparam int FLG_LSB = 2 * CNT_W + 64;
  localparam int KEY_LSB = 2 * CNT_W + 72;
  localparam int VLD_BIT = KEY_LSB + KEY_W;
  localparam logic [PW-1:0] LAST_PROBE = PW'(PROBE_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, READ, LOOKUP, WRITE, EXPORT_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [ADDR_W-1:0]  hash_q, hash_d;
  logic [15:0]        len_q, len_d;
  logic [31:0]        ts_q, ts_d;
  logic [7:0]         flags_q, flags_d;
  logic               export_req_q, export_req_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ENTRY_W-1:0] mem_din_q, mem_din_d;
  logic               export_valid_q, export_valid_d;
  logic [ADDR_W-1:0]  export_addr_q, export_addr_d;
  logic [31:0]        collision_q, collision_d;
  logic [31:0]        probe_q, probe_d;

  // Fields of the record read back in LOOKUP. The stored last_ts is always
  // overwritten, so it is never consulted.
  logic               rd_valid;
  logic [KEY_W-1:0]   rd_key;
  logic [7:0]         rd_flags;
  logic [31:0]        rd_first_ts;
  logic [31:0]        unused_last_ts;
  logic [CNT_W-1:0]   rd_pkt, rd_bytes;
  logic               key_match;

  assign rd_valid       = mem_dout[VLD_BIT];
  assign rd_key         = mem_dout[KEY_LSB +: KEY_W];
  assign rd_flags       = mem_dout[FLG_LSB +: 8];
  assign rd_first_ts    = mem_dout[FTS_LSB +: 32];
  assign unused_last_ts = mem_dout[LTS_LSB +: 32];
  assign rd_pkt         = mem_dout[PKT_LSB +: CNT_W];
  assign rd_bytes       = mem_dout[CNT_W-1:0];
  assign key_match      = (rd_key == key_q);

  // Candidate record for the probed slot: a fresh flow when the slot is
  // empty, otherwise the stored flow merged with this packet.
  logic [7:0]       new_flags;
  logic [31:0]      new_first_ts;
  logic [CNT_W-1:0] new_pkt, new_bytes;
  logic [CNT_W:0]   byte_sum;
  logic             need_export;

  always_comb begin
    byte_sum     = {1'b0, rd_bytes} + (CNT_W + 1)'(len_q);
    new_flags    = flags_q;
    new_first_ts = ts_q;
    new_pkt      = CNT_W'(1);
    new_bytes    = CNT_W'(len_q);
    if (rd_valid) begin
      new_flags    = rd_flags | flags_q;
      new_first_ts = rd_first_ts;
      new_pkt      = (rd_pkt == '1) ? rd_pkt : rd_pkt + CNT_W'(1);
      new_bytes    = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
    end
    // TCP FIN/RST closes the flow; a saturated counter can no longer count.
    need_export = ((key_q[7:0] == 8'd6) && (flags_q[0] || flags_q[2])) ||
                  (new_pkt == '1) || (new_bytes == '1);
  end

  // Next-state logic. Every output is a flop, so the RAM strobes and
  // in_ready are decoded from the state being entered.
  always_comb begin
    state_d        = state_q;
    p_d            = p_q;
    key_d          = key_q;
    hash_d         = hash_q;
    len_d          = len_q;
    ts_d           = ts_q;
    flags_d        = flags_q;
    export_req_d   = export_req_q;
    mem_din_d      = mem_din_q;
    export_valid_d = export_valid_q;
    export_addr_d  = export_addr_q;
    collision_d    = collision_q;
    probe_d        = probe_q;

    // A completed transfer frees the export slot unless reloaded below.
    if (export_valid_q && export_ready) begin
      export_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          key_d   = in_key;
          hash_d  = in_hash;
          len_d   = in_len;
          ts_d    = in_ts;
          flags_d = in_flags;
          p_d     = '0;
          state_d = READ;
        end
      end
      READ: state_d = LOOKUP;
      LOOKUP: begin
        if (!rd_valid || key_match) begin
          mem_din_d    = {1'b1, key_q, new_flags, new_first_ts, ts_q, new_pkt, new_bytes};
          export_req_d = need_export;
          state_d      = WRITE;
        end else if (p_q != LAST_PROBE) begin
          p_d     = p_q + PW'(1);
          probe_d = probe_q + 32'd1;
          state_d = READ;
        end else begin
          if (collision_q != '1) begin
            collision_d = collision_q + 32'd1;
          end
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (!export_req_q) begin
          state_d = IDLE;
        end else if (!export_valid_q || export_ready) begin
          export_valid_d = 1'b1;
          export_addr_d  = mem_addr_q;
          state_d        = IDLE;
        end else begin
          state_d = EXPORT_WAIT;
        end
      end
      EXPORT_WAIT: begin
        if (export_valid_q && export_ready) begin
          export_valid_d = 1'b1;
          export_addr_d  = mem_addr_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The probed slot wraps naturally at the top of the table.
    mem_addr_d = hash_d + ADDR_W'(p_d);
    in_ready_d = (state_d == IDLE);
    mem_en_d   = (state_d == READ) || (state_d == WRITE);
    mem_we_d   = (state_d == WRITE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      p_q            <= '0;
      key_q          <= '0;
      hash_q         <= '0;
      len_q          <= '0;
      ts_q           <= '0;
      flags_q        <= '0;
      export_req_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      export_valid_q <= 1'b0;
      export_addr_q  <= '0;
      collision_q    <= '0;
      probe_q        <= '0;
    end else begin
      state_q        <= state_d;
      p_q            <= p_d;
      key_q          <= key_d;
      hash_q         <= hash_d;
      len_q          <= len_d;
      ts_q           <= ts_d;
      flags_q        <= flags_d;
      export_req_q   <= export_req_d;
      in_ready_q     <= in_ready_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      export_valid_q <= export_valid_d;
      export_addr_q  <= export_addr_d;
      collision_q    <= collision_d;
      probe_q        <= probe_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign mem_en            = mem_en_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_din           = mem_din_q;
  assign export_valid      = export_valid_q;
  assign export_addr       = export_addr_q;
  assign collision_counter = collision_q;
  assign probe_counter     = probe_q;

endmodule

// File: tb/tb_flow_table_updater.sv
// tb_flow_table_updater
//
// Directed bench for flow_table_updater at default parameters. A behavioural
// single-port RAM stands in for the flow table; every expected record and
// counter value below is worked out by hand from the packet sequence.

module tb_flow_table_updater;

  logic         ACLK;
  logic         ARESETN;
  logic         in_valid;
  logic         in_ready;
  logic [103:0] in_key;
  logic [11:0]  in_hash;
  logic [15:0]  in_len;
  logic [31:0]  in_ts;
  logic [7:0]   in_flags;
  logic         mem_en;
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [240:0] mem_din;
  logic [240:0] mem_dout;
  logic         export_valid;
  logic         export_ready;
  logic [11:0]  export_addr;
  logic [31:0]  collision_counter;
  logic [31:0]  probe_counter;

  flow_table_updater dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_key            (in_key),
    .in_hash           (in_hash),
    .in_len            (in_len),
    .in_ts             (in_ts),
    .in_flags          (in_flags),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .export_valid      (export_valid),
    .export_ready      (export_ready),
    .export_addr       (export_addr),
    .collision_counter (collision_counter),
    .probe_counter     (probe_counter)
  );

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  logic [240:0] ram [4096];
  int           writeCount = 0;
  logic [11:0]  lastWriteAddr = '0;

  localparam logic [103:0] KEY_UDP  = 104'hC0A80001_C0A80002_1F90_0035_11;
  localparam logic [103:0] KEY_TCP  = 104'hC0A80003_C0A80004_C350_0050_06;
  localparam logic [103:0] KEY_TCP2 = 104'hC0A80005_C0A80006_C351_01BB_06;
  localparam logic [103:0] KEY_F1   = 104'h0A000001_0A000002_0001_0002_11;
  localparam logic [103:0] KEY_F2   = 104'h0A000001_0A000002_0003_0004_11;
  localparam logic [103:0] KEY_F3   = 104'h0A000001_0A000002_0005_0006_11;
  localparam logic [103:0] KEY_F4   = 104'h0A000001_0A000002_0007_0008_11;
  localparam logic [103:0] KEY_F5   = 104'h0A000001_0A000002_0009_000A_11;
  localparam logic [103:0] KEY_F6   = 104'h0A000001_0A000002_000B_000C_11;
  localparam logic [103:0] KEY_NEW  = 104'hAC100001_AC100002_2000_3000_11;
  localparam logic [103:0] KEY_COL  = 104'hAC100003_AC100004_2001_3001_11;
  localparam logic [103:0] KEY_SAT  = 104'hAC100005_AC100006_4000_5000_11;
  localparam logic [103:0] KEY_RST  = 104'hAC100007_AC100008_4001_5001_11;

  // Free-running clock, 10 time units per cycle.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Flow table RAM: one-cycle read latency, write on enable + write enable.
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_din;
        writeCount    = writeCount + 1;
        lastWriteAddr = mem_addr;
      end else begin
        mem_dout <= ram[mem_addr];
      end
    end
  end

  // Safety net so a stuck design can never hang the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [240:0] makeRec(input logic [103:0] k, input logic [7:0] f,
                                           input logic [31:0] fts, input logic [31:0] lts,
                                           input logic [31:0] pc, input logic [31:0] bc);
    return {1'b1, k, f, fts, lts, pc, bc};
  endfunction

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one descriptor as soon as in_ready is seen, holds it for the
  // accepting edge, and returns #1 after that edge (the READ cycle).
  task automatic applyStimulus(input logic [103:0] k, input logic [11:0] h,
                               input logic [15:0] l, input logic [31:0] t,
                               input logic [7:0] f);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (in_ready !== 1'b1) checkOutput("in_ready before send", in_ready, 1);
    in_key   = k;
    in_hash  = h;
    in_len   = l;
    in_ts    = t;
    in_flags = f;
    in_valid = 1'b1;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for the engine to return to IDLE.
  task automatic waitIdle(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (in_ready !== 1'b1) checkOutput(tag, in_ready, 1);
  endtask

  initial begin
    int wBefore;

    ARESETN      = 1'b0;
    in_valid     = 1'b0;
    in_key       = '0;
    in_hash      = '0;
    in_len       = '0;
    in_ts        = '0;
    in_flags     = '0;
    export_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = '0;

    // Reset state: every output low, including in_ready.
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset mem_en", mem_en, 0);
    checkOutput("reset export_valid", export_valid, 0);
    checkOutput("reset collision_counter", collision_counter, 0);
    checkOutput("reset probe_counter", probe_counter, 0);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("idle in_ready", in_ready, 1);

    // Empty table, first UDP packet: cycle-by-cycle view of the transaction.
    applyStimulus(KEY_UDP, 12'h010, 16'd100, 32'd5, 8'h00);
    checkOutput("t1 read in_ready", in_ready, 0);
    checkOutput("t1 read mem_en", mem_en, 1);
    checkOutput("t1 read mem_we", mem_we, 0);
    checkOutput("t1 read mem_addr", mem_addr, 12'h010);
    @(posedge ACLK); #1;
    checkOutput("t1 lookup mem_en", mem_en, 0);
    checkOutput("t1 lookup in_ready", in_ready, 0);
    @(posedge ACLK); #1;
    checkOutput("t1 write mem_en", mem_en, 1);
    checkOutput("t1 write mem_we", mem_we, 1);
    checkOutput("t1 write mem_addr", mem_addr, 12'h010);
    checkOutput("t1 write mem_din", mem_din, makeRec(KEY_UDP, 8'h00, 32'd5, 32'd5, 32'd1, 32'd100));
    checkOutput("t1 write in_ready", in_ready, 0);
    @(posedge ACLK); #1;
    checkOutput("t1 done in_ready", in_ready, 1);
    checkOutput("t1 done mem_en", mem_en, 0);
    checkOutput("t1 no export", export_valid, 0);
    checkOutput("t1 ram", ram[12'h010], makeRec(KEY_UDP, 8'h00, 32'd5, 32'd5, 32'd1, 32'd100));
    checkOutput("t1 write count", writeCount, 1);

    // Same flow again: counters add up, first_ts kept, flags OR'd.
    applyStimulus(KEY_UDP, 12'h010, 16'd60, 32'd9, 8'h10);
    waitIdle("t2 idle timeout");
    checkOutput("t2 ram", ram[12'h010], makeRec(KEY_UDP, 8'h10, 32'd5, 32'd9, 32'd2, 32'd160));
    checkOutput("t2 no export", export_valid, 0);

    // TCP FIN with the exporter stalled: request appears and is held stable.
    applyStimulus(KEY_TCP, 12'h100, 16'd40, 32'd20, 8'h01);
    waitIdle("t3 idle timeout");
    checkOutput("t3 export_valid", export_valid, 1);
    checkOutput("t3 export_addr", export_addr, 12'h100);
    checkOutput("t3 ram", ram[12'h100], makeRec(KEY_TCP, 8'h01, 32'd20, 32'd20, 32'd1, 32'd40));
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("t3 held valid", export_valid, 1);
    checkOutput("t3 held addr", export_addr, 12'h100);

    // Second FIN/RST packet writes, then parks until the first export goes.
    applyStimulus(KEY_TCP2, 12'h200, 16'd52, 32'd21, 8'h05);
    repeat (6) @(posedge ACLK);
    #1;
    checkOutput("t3b stalled in_ready", in_ready, 0);
    checkOutput("t3b old addr", export_addr, 12'h100);
    checkOutput("t3b ram", ram[12'h200], makeRec(KEY_TCP2, 8'h05, 32'd21, 32'd21, 32'd1, 32'd52));
    export_ready = 1'b1;
    @(posedge ACLK); #1;
    export_ready = 1'b0;
    checkOutput("t3b new valid", export_valid, 1);
    checkOutput("t3b new addr", export_addr, 12'h200);
    checkOutput("t3b released in_ready", in_ready, 1);
    export_ready = 1'b1;
    @(posedge ACLK); #1;
    export_ready = 1'b0;
    checkOutput("t3b export drained", export_valid, 0);

    // Probing wraps from the top of the table to slot 0.
    ram[12'hFFE] = makeRec(KEY_F1, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    ram[12'hFFF] = makeRec(KEY_F2, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    applyStimulus(KEY_NEW, 12'hFFE, 16'd80, 32'd30, 8'h00);
    waitIdle("t4 idle timeout");
    checkOutput("t4 write addr", lastWriteAddr, 12'h000);
    checkOutput("t4 ram", ram[12'h000], makeRec(KEY_NEW, 8'h00, 32'd30, 32'd30, 32'd1, 32'd80));
    checkOutput("t4 probe_counter", probe_counter, 2);

    // All four candidate slots foreign: drop, no write.
    ram[12'h300] = makeRec(KEY_F3, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    ram[12'h301] = makeRec(KEY_F4, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    ram[12'h302] = makeRec(KEY_F5, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    ram[12'h303] = makeRec(KEY_F6, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64);
    wBefore = writeCount;
    applyStimulus(KEY_COL, 12'h300, 16'd70, 32'd35, 8'h00);
    waitIdle("t5 idle timeout");
    checkOutput("t5 no write", writeCount, wBefore);
    checkOutput("t5 collision_counter", collision_counter, 1);
    checkOutput("t5 probe_counter", probe_counter, 5);
    checkOutput("t5 slot untouched", ram[12'h303], makeRec(KEY_F6, 8'h00, 32'd1, 32'd1, 32'd1, 32'd64));

    // Packet counter one below saturation: two packets, both saturate/export.
    ram[12'h400] = makeRec(KEY_SAT, 8'h00, 32'd40, 32'd40, 32'hFFFF_FFFE, 32'd1000);
    applyStimulus(KEY_SAT, 12'h400, 16'd10, 32'd41, 8'h00);
    waitIdle("t6 idle timeout");
    checkOutput("t6a ram", ram[12'h400], makeRec(KEY_SAT, 8'h00, 32'd40, 32'd41, 32'hFFFF_FFFF, 32'd1010));
    checkOutput("t6a export_valid", export_valid, 1);
    checkOutput("t6a export_addr", export_addr, 12'h400);
    export_ready = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("t6a export taken", export_valid, 0);
    applyStimulus(KEY_SAT, 12'h400, 16'd10, 32'd42, 8'h00);
    waitIdle("t6 idle timeout 2");
    export_ready = 1'b0;
    checkOutput("t6b ram", ram[12'h400], makeRec(KEY_SAT, 8'h00, 32'd40, 32'd42, 32'hFFFF_FFFF, 32'd1020));
    checkOutput("t6b export_valid", export_valid, 1);
    checkOutput("t6b export_addr", export_addr, 12'h400);

    // Reset during LOOKUP with an export still pending: nothing is written.
    wBefore = writeCount;
    applyStimulus(KEY_RST, 12'h500, 16'd90, 32'd50, 8'h00);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    #1;
    checkOutput("t7 in_ready", in_ready, 0);
    checkOutput("t7 mem_en", mem_en, 0);
    checkOutput("t7 mem_addr", mem_addr, 0);
    checkOutput("t7 export_valid", export_valid, 0);
    checkOutput("t7 export_addr", export_addr, 0);
    checkOutput("t7 collision_counter", collision_counter, 0);
    checkOutput("t7 probe_counter", probe_counter, 0);
    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("t7 no write", writeCount, wBefore);
    checkOutput("t7 ram empty", ram[12'h500], 0);
    ARESETN = 1'b1;
    waitIdle("t7 recover timeout");
    checkOutput("t7 recovered", in_ready, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
